sel_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 2:1 selector datapath (inputs a, b, select line sel, output out).
- Two requesters compete for the selector. The block grants one at a time and drives sel.
- It registers the selected data onto out and flags it with out_valid.
- A hold limit bounds how long one requester can keep the path while the other waits.

---
 rtl/sel_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_sel_rr_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sel_rr_arbiter.sv
// sel_rr_arbiter: two-way round-robin arbiter driving a shared 2:1 selector.
// The grant owner steers sel, and its data is registered onto out with out_valid.
// While the other side is waiting, one owner can keep the path for at most
// MAX_HOLD consecutive cycles before the grant is forced across.
module sel_rr_arbiter #(
    parameter int DATA_W   = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              sel,
    output logic [DATA_W-1:0] out,
    output logic              out_valid
);

    // hold_cnt holds 0..MAX_HOLD-1. Its width is sized for MAX_HOLD+1 values.
    localparam int HCW = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [HCW-1:0]  hold_reg, hold_next;
    // last_b_reg = 1 means B was granted most recently, so A wins the next tie.
    logic            last_b_reg, last_b_next;

    // State register: arbitration state, contention counter, and fairness pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            hold_reg   <= '0;
            last_b_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            hold_reg   <= hold_next;
            last_b_reg <= last_b_next;
        end
    end

    // Next-state logic: round-robin on ties, and a forced switch after MAX_HOLD contended cycles.
    always_comb begin
        state_next  = state_reg;
        hold_next   = hold_reg;
        last_b_next = last_b_reg;
        case (state_reg)
            IDLE: begin
                if (req_a && req_b) begin
                    state_next = last_b_reg ? GNT_A : GNT_B;
                end else if (req_a) begin
                    state_next = GNT_A;
                end else if (req_b) begin
                    state_next = GNT_B;
                end
            end
            GNT_A: begin
                if (req_a) begin
                    if (req_b) begin
                        if (hold_reg == HOLD_LAST) begin
                            state_next = GNT_B;
                        end else begin
                            hold_next = hold_reg + HCW'(1);
                        end
                    end else begin
                        // The other side stopped waiting, so contention starts over.
                        hold_next = '0;
                    end
                end else if (req_b) begin
                    state_next = GNT_B;
                end else begin
                    state_next = IDLE;
                end
            end
            GNT_B: begin
                if (req_b) begin
                    if (req_a) begin
                        if (hold_reg == HOLD_LAST) begin
                            state_next = GNT_A;
                        end else begin
                            hold_next = hold_reg + HCW'(1);
                        end
                    end else begin
                        hold_next = '0;
                    end
                end else if (req_a) begin
                    state_next = GNT_A;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A fresh grant (from IDLE or a handover) restarts the count and moves the pointer.
        if ((state_next != state_reg) && (state_next != IDLE)) begin
            hold_next   = '0;
            last_b_next = (state_next == GNT_B);
        end
        if (state_next == IDLE) begin
            hold_next = '0;
        end
    end

    // Output decode: grants and select come straight from the state register.
    always_comb begin
        gnt_a = (state_reg == GNT_A);
        gnt_b = (state_reg == GNT_B);
        sel   = (state_reg == GNT_A);
    end

    // Datapath register: capture the owner's data. In IDLE, hold out and drop valid one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state_reg)
                GNT_A:   out <= a;
                GNT_B:   out <= b;
                default: out <= out;
            endcase
            out_valid <= (state_reg != IDLE);
        end
    end

endmodule

// File: tb/tb_sel_rr_arbiter.sv
// tb_sel_rr_arbiter: drives two arbiters (MAX_HOLD=4 and MAX_HOLD=1, DATA_W=4) from the
// same stimulus. It checks each one against an ownership-level reference model.
module tb_sel_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b;
    logic [3:0] a, b;

    logic [1:0] gnt_a_w, gnt_b_w, sel_w, vld_w;
    logic [3:0] out_w [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state per instance. owner: 0 = none, 1 = A, 2 = B.
    int         m_owner  [2];
    int         m_waited [2];
    int         m_last   [2];
    logic [3:0] m_out    [2];
    logic       m_val    [2];
    int         maxh     [2];

    always #5 clk = ~clk;

    sel_rr_arbiter #(.DATA_W(4), .MAX_HOLD(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(gnt_a_w[0]), .gnt_b(gnt_b_w[0]), .sel(sel_w[0]),
        .out(out_w[0]), .out_valid(vld_w[0])
    );

    sel_rr_arbiter #(.DATA_W(4), .MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .a(a), .b(b),
        .gnt_a(gnt_a_w[1]), .gnt_b(gnt_b_w[1]), .sel(sel_w[1]),
        .out(out_w[1]), .out_valid(vld_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i]  = 0;
            m_waited[i] = 0;
            m_last[i]   = 2;
            m_out[i]    = 4'h0;
            m_val[i]    = 1'b0;
        end
    endtask

    // One rising edge of the model. The data register follows the owner that held the
    // path before the edge. Ownership then moves according to the arbitration rules.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int  ow;
            int  nxt;
            logic mine, oth;
            ow  = m_owner[i];
            nxt = ow;
            if (ow == 1) begin
                m_out[i] = a;
                m_val[i] = 1'b1;
            end else if (ow == 2) begin
                m_out[i] = b;
                m_val[i] = 1'b1;
            end else begin
                m_val[i] = 1'b0;
            end

            if (ow == 0) begin
                if (req_a && req_b) nxt = (m_last[i] == 1) ? 2 : 1;
                else if (req_a)     nxt = 1;
                else if (req_b)     nxt = 2;
            end else begin
                mine = (ow == 1) ? req_a : req_b;
                oth  = (ow == 1) ? req_b : req_a;
                if (mine && oth) begin
                    // The other side has now waited one more granted cycle.
                    if (m_waited[i] + 1 >= maxh[i]) nxt = 3 - ow;
                    else                            m_waited[i]++;
                end else if (mine) begin
                    m_waited[i] = 0;
                end else if (oth) begin
                    nxt = 3 - ow;
                end else begin
                    nxt = 0;
                end
            end

            if (nxt != ow) begin
                m_waited[i] = 0;
                if (nxt != 0) m_last[i] = nxt;
            end
            m_owner[i] = nxt;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d.gnt_a", i), 32'(gnt_a_w[i]), 32'(m_owner[i] == 1));
            chk($sformatf("u%0d.gnt_b", i), 32'(gnt_b_w[i]), 32'(m_owner[i] == 2));
            chk($sformatf("u%0d.sel", i),   32'(sel_w[i]),   32'(m_owner[i] == 1));
            chk($sformatf("u%0d.out", i),   32'(out_w[i]),   32'(m_out[i]));
            chk($sformatf("u%0d.valid", i), 32'(vld_w[i]),   32'(m_val[i]));
        end
    endtask

    // Apply inputs just after an edge, let the next edge happen, and check 1 time unit later.
    task automatic step(input logic ra, input logic rb, input logic [3:0] da, input logic [3:0] db);
        req_a = ra;
        req_b = rb;
        a     = da;
        b     = db;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        maxh[0] = 4;
        maxh[1] = 1;
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        a     = 4'h0;
        b     = 4'h0;
        model_reset();
        #12;
        rst_n = 1'b1;
        #1;
        check_all();

        // Reset mid-grant. The async reset clears outputs at once, and B then wins alone.
        step(1'b1, 1'b0, 4'h1, 4'h0);
        step(1'b1, 1'b0, 4'h1, 4'h0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #2;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 4'h1, 4'h0);
        step(1'b0, 1'b0, 4'h1, 4'h0);
        step(1'b0, 1'b0, 4'h1, 4'h0);

        // Single requester holds the path indefinitely.
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 4'h1, 4'h0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'h1, 4'h0);

        // Tie from a fresh reset. A goes first, and the hold limit forces alternation.
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) step(1'b1, 1'b1, 4'hA, 4'h5);

        // Handover from B to A with no idle bubble.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 4'hA, 4'h5);
        step(1'b1, 1'b0, 4'hA, 4'h5);
        step(1'b1, 1'b0, 4'hA, 4'h5);

        // Both drop. out holds its last value and valid falls one edge later.
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'h3, 4'hC);

        // Randomized traffic, biased toward contention.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                 4'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
